// File: rtl/audio_player_ctrl.sv
// Playback controller: debounced buttons/switches, play/pause FSM, wrap-around track select, mm:ss timer, 7-seg drive.
// Button events act DEBOUNCE_CYCLES+3 cycles after a raw edge; track_end acts next cycle; no backpressure (all inputs are levels/pulses).
module audio_player_ctrl #(
  parameter int CLK_HZ          = 50000000,
  parameter int NUM_TRACKS      = 8,
  parameter int TRACK_W         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESTART_SEC     = 3,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               anterior_sw,
  input  logic               siguiente_sw,
  input  logic               pausa_sw,
  input  logic [1:0]         filt_sw,
  input  logic               track_end,
  output logic [TRACK_W-1:0] track,
  output logic               playing,
  output logic               track_start,
  output logic [1:0]         filt_mode,
  output logic [6:0]         min1,
  output logic [6:0]         min2,
  output logic [6:0]         seg1,
  output logic [6:0]         seg2
);

  localparam int NIN   = 5;
  localparam int ANT   = 0;
  localparam int SIG   = 1;
  localparam int PAU   = 2;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [NIN-1:0] REL_LVL = 5'b00111;

  typedef enum logic {ST_PAUSE, ST_PLAY} state_t;

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h3F;
    endcase
    return (SEG_ACTIVE_LOW != 0) ? ~p : p;
  endfunction

  logic [NIN-1:0] raw_w;
  logic [NIN-1:0] sync1_q, sync2_q, db_q, db_d;
  logic [CNT_W-1:0] cnt_q [NIN];
  logic [CNT_W-1:0] cnt_d [NIN];
  logic [2:0]     ev_q, ev_d;

  assign raw_w = {filt_sw[1], filt_sw[0], pausa_sw, siguiente_sw, anterior_sw};

  // A differing sample extends the run; a matching one (bounce) restarts it.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d[i] = sync2_q[i];
        else                                         cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    ev_d = db_q[2:0] & ~db_d[2:0];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
      db_q    <= REL_LVL;
      ev_q    <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      ev_q    <= ev_d;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  state_t             state_q, state_d;
  logic [TRACK_W-1:0] track_q, track_d;
  logic               start_q, start_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [3:0]         sec_u_q, sec_u_d, sec_t_q, sec_t_d;
  logic [3:0]         min_u_q, min_u_d, min_t_q, min_t_d;
  logic [6:0]         min1_q, min2_q, seg1_q, seg2_q;
  logic [13:0]        elapsed_s;
  logic               adv, back, saturated;

  assign elapsed_s = 14'(min_t_q) * 14'd600 + 14'(min_u_q) * 14'd60
                   + 14'(sec_t_q) * 14'd10 + 14'(sec_u_q);
  assign adv       = ev_q[SIG] | (track_end & (state_q == ST_PLAY));
  assign back      = ev_q[ANT];
  assign saturated = (min_t_q == 4'd9) && (min_u_q == 4'd9) && (sec_t_q == 4'd5) && (sec_u_q == 4'd9);

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    start_d = 1'b0;
    presc_d = presc_q;
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;

    if (ev_q[PAU]) state_d = (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;

    if (adv || back) begin
      start_d = 1'b1;
      presc_d = '0;
      sec_u_d = '0;
      sec_t_d = '0;
      min_u_d = '0;
      min_t_d = '0;
      if (adv) begin
        track_d = (track_q == TRACK_W'(NUM_TRACKS - 1)) ? '0 : track_q + TRACK_W'(1);
      end else if (elapsed_s < 14'(RESTART_SEC)) begin
        track_d = (track_q == '0) ? TRACK_W'(NUM_TRACKS - 1) : track_q - TRACK_W'(1);
      end
    end else if (state_q == ST_PLAY) begin
      if (presc_q == PRE_W'(CLK_HZ - 1)) begin
        presc_d = '0;
        if (!saturated) begin
          if (sec_u_q != 4'd9) sec_u_d = sec_u_q + 4'd1;
          else begin
            sec_u_d = '0;
            if (sec_t_q != 4'd5) sec_t_d = sec_t_q + 4'd1;
            else begin
              sec_t_d = '0;
              if (min_u_q != 4'd9) min_u_d = min_u_q + 4'd1;
              else begin
                min_u_d = '0;
                min_t_d = min_t_q + 4'd1;
              end
            end
          end
        end
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_PAUSE;
      track_q <= '0;
      start_q <= 1'b0;
      presc_q <= '0;
      sec_u_q <= '0;
      sec_t_q <= '0;
      min_u_q <= '0;
      min_t_q <= '0;
      min1_q  <= seg_dec(4'd0);
      min2_q  <= seg_dec(4'd0);
      seg1_q  <= seg_dec(4'd0);
      seg2_q  <= seg_dec(4'd0);
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      start_q <= start_d;
      presc_q <= presc_d;
      sec_u_q <= sec_u_d;
      sec_t_q <= sec_t_d;
      min_u_q <= min_u_d;
      min_t_q <= min_t_d;
      min1_q  <= seg_dec(min_t_q);
      min2_q  <= seg_dec(min_u_q);
      seg1_q  <= seg_dec(sec_t_q);
      seg2_q  <= seg_dec(sec_u_q);
    end
  end

  assign track       = track_q;
  assign playing     = (state_q == ST_PLAY);
  assign track_start = start_q;
  assign filt_mode   = db_q[4:3];
  assign min1        = min1_q;
  assign min2        = min2_q;
  assign seg1        = seg1_q;
  assign seg2        = seg2_q;

endmodule

// File: tb/tb_audio_player_ctrl.sv
// Directed bench for audio_player_ctrl with small clock/debounce parameters.
module tb_audio_player_ctrl;

  localparam int ANT = 0;
  localparam int SIG = 1;
  localparam int PAU = 2;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       anterior_sw, siguiente_sw, pausa_sw, track_end;
  logic [1:0] filt_sw;
  logic [1:0] track;
  logic       playing, track_start;
  logic [1:0] filt_mode;
  logic [6:0] min1, min2, seg1, seg2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ts_cnt   = 0;
  int ts0, p0, p1, p2, pz, exp_s;

  audio_player_ctrl #(
    .CLK_HZ(10), .NUM_TRACKS(4), .TRACK_W(2), .DEBOUNCE_CYCLES(4),
    .RESTART_SEC(3), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .anterior_sw(anterior_sw), .siguiente_sw(siguiente_sw), .pausa_sw(pausa_sw),
    .filt_sw(filt_sw), .track_end(track_end),
    .track(track), .playing(playing), .track_start(track_start), .filt_mode(filt_mode),
    .min1(min1), .min2(min2), .seg1(seg1), .seg2(seg2)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) if (track_start) ts_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic check_time(input string tag, input int mm, input int ss);
    check({tag, "_min1"}, min1, seg_exp(mm / 10));
    check({tag, "_min2"}, min2, seg_exp(mm % 10));
    check({tag, "_seg1"}, seg1, seg_exp(ss / 10));
    check({tag, "_seg2"}, seg2, seg_exp(ss % 10));
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      ANT:     anterior_sw  = v;
      SIG:     siguiente_sw = v;
      default: pausa_sw     = v;
    endcase
  endtask

  // Leaves the bench on the cycle the event's effect first becomes visible.
  task automatic btn_press(input int b);
    set_btn(b, 1'b0);
    repeat (7) tick();
  endtask

  task automatic btn_release(input int b);
    set_btn(b, 1'b1);
    repeat (10) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_track"}, track, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_tstart"}, track_start, 0);
    check({tag, "_filt"}, filt_mode, 0);
    check_time(tag, 0, 0);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    anterior_sw = 1'b1; siguiente_sw = 1'b1; pausa_sw = 1'b1;
    filt_sw = 2'b00; track_end = 1'b0;
    #12;
    check_reset("rst");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (3) tick();

    // Filter switches: level accepted after sync + debounce.
    filt_sw = 2'b10;
    repeat (5) tick();
    check("filt_early", filt_mode, 0);
    tick();
    check("filt_lvl", filt_mode, 2'b10);

    // First pausa press: PLAY on the 7th cycle.
    pausa_sw = 1'b0;
    repeat (6) tick();
    check("pau_early", playing, 0);
    tick();
    check("pau_play", playing, 1);
    p0 = cyc;
    repeat (3) tick();
    pausa_sw = 1'b1;
    wait_until(p0 + 101);
    check_time("t10", 0, 10);

    // Short glitch must be rejected.
    pausa_sw = 1'b0;
    repeat (2) tick();
    pausa_sw = 1'b1;
    repeat (10) tick();
    check("glitch", playing, 1);

    btn_press(PAU);
    check("pau_pause", playing, 0);
    pz = cyc;
    exp_s = (pz - p0) / 10;
    btn_release(PAU);
    repeat (50) tick();
    check_time("hold", exp_s / 60, exp_s % 60);
    check("hold_play", playing, 0);

    for (int n = 1; n <= 4; n++) begin
      ts0 = ts_cnt;
      btn_press(SIG);
      check("sig_trk", track, n % 4);
      check("sig_ts1", track_start, 1);
      tick();
      check("sig_ts0", track_start, 0);
      check("sig_tscnt", ts_cnt, ts0 + 1);
      check_time("sig_t", 0, 0);
      btn_release(SIG);
    end
    for (int n = 1; n <= 2; n++) begin
      btn_press(SIG);
      btn_release(SIG);
    end
    check("to_trk2", track, 2);

    // PLAY on track 2, anterior at 00:05 restarts.
    btn_press(PAU);
    check("pau_play2", playing, 1);
    p1 = cyc;
    btn_release(PAU);
    wait_until(p1 + 48);
    ts0 = ts_cnt;
    btn_press(ANT);
    check("ant_rst_trk", track, 2);
    check("ant_rst_ts", track_start, 1);
    tick();
    check_time("ant_rst_t", 0, 0);
    check("ant_rst_cnt", ts_cnt, ts0 + 1);
    btn_release(ANT);

    btn_press(ANT);
    check("ant_prev1", track, 1);
    tick();
    check_time("ant_prev_t", 0, 0);
    btn_release(ANT);
    btn_press(ANT);
    check("ant_prev0", track, 0);
    tick();
    btn_release(ANT);
    btn_press(ANT);
    check("ant_wrap", track, 3);
    tick();
    btn_release(ANT);

    // track_end alone while playing wraps 3 -> 0.
    track_end = 1'b1;
    tick();
    track_end = 1'b0;
    check("tend_play", track, 0);
    check("tend_ts", track_start, 1);
    btn_press(SIG);
    check("to_trk1", track, 1);
    tick();
    btn_release(SIG);

    // siguiente event and track_end in the same cycle advance once.
    ts0 = ts_cnt;
    siguiente_sw = 1'b0;
    repeat (6) tick();
    track_end = 1'b1;
    tick();
    track_end = 1'b0;
    check("both_trk", track, 2);
    check("both_ts", track_start, 1);
    tick();
    check("both_ts0", track_start, 0);
    check("both_cnt", ts_cnt, ts0 + 1);
    btn_release(SIG);

    btn_press(PAU);
    check("pau_pause2", playing, 0);
    btn_release(PAU);
    ts0 = ts_cnt;
    track_end = 1'b1;
    tick();
    track_end = 1'b0;
    tick();
    check("tend_pause_trk", track, 2);
    check("tend_pause_cnt", ts_cnt, ts0);

    // Long run to saturation from 00:00.
    btn_press(SIG);
    check("sat_trk", track, 3);
    tick();
    btn_release(SIG);
    btn_press(PAU);
    check("pau_play3", playing, 1);
    p2 = cyc;
    btn_release(PAU);
    wait_until(p2 + 601);
    check_time("t100", 1, 0);
    wait_until(p2 + 59981);
    check_time("t9958", 99, 58);
    wait_until(p2 + 59991);
    check_time("t9959", 99, 59);
    wait_until(p2 + 60021);
    check_time("sat", 99, 59);
    check("sat_play", playing, 1);

    // Asynchronous reset mid-count.
    #3;
    reset_reset_n = 1'b0;
    #1;
    check_reset("arst");
    #20;
    reset_reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
